// File: rtl/mgmt_port_regbank.sv
// Per-port configuration/status register bank on the management bus.
// Multi-byte registers are written atomically through a staging buffer and read atomically through a snapshot.
module mgmt_port_regbank #(
    parameter int                   NUM_PORTS  = 15,
    parameter int                   PORT_BITS  = 4,
    parameter int                   REGID_BITS = 10,
    parameter int                   NUM_REGS   = 4,
    parameter int                   REG_BYTES  = 2,
    parameter logic [15:0]          BASE_ADDR  = 16'h4000,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        rd_en,
    input  logic [15:0]                                 rd_addr,
    output logic                                        rd_valid,
    output logic [7:0]                                  rd_data,
    output logic                                        rd_err,
    input  logic                                        wr_en,
    input  logic [15:0]                                 wr_addr,
    input  logic [7:0]                                  wr_data,
    output logic [NUM_PORTS*NUM_REGS*REG_BYTES*8-1:0]   cfg_out,
    output logic [NUM_PORTS*NUM_REGS-1:0]               cfg_updated,
    input  logic [NUM_PORTS*NUM_REGS*REG_BYTES*8-1:0]   stat_in
);

    localparam int REG_W     = REG_BYTES * 8;
    localparam int NUM_SLOTS = NUM_PORTS * NUM_REGS;
    localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int TAG_W     = PORT_BITS + IDX_W;
    localparam int STG_N     = (REG_BYTES > 1) ? REG_BYTES - 1 : 1;
    localparam int RID_HI_W  = REGID_BITS - 2;

    // Address decode: channel 0 is the read port, channel 1 the write port.
    logic [15:0]          dec_addr [2];
    logic                 dec_hit  [2];
    logic [PORT_BITS-1:0] dec_port [2];
    logic [IDX_W-1:0]     dec_idx  [2];
    logic [1:0]           dec_byte [2];
    logic [SLOT_W-1:0]    dec_slot [2];

    assign dec_addr[0] = rd_addr;
    assign dec_addr[1] = wr_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            logic [15:0]           diff;
            logic [REGID_BITS-1:0] regid;
            logic [RID_HI_W-1:0]   idx_full;

            assign diff          = dec_addr[gi] - BASE_ADDR;
            assign dec_port[gi]  = PORT_BITS'(diff >> REGID_BITS);
            assign regid         = REGID_BITS'(diff);
            assign idx_full      = regid[REGID_BITS-1:2];
            assign dec_byte[gi]  = regid[1:0];
            assign dec_idx[gi]   = IDX_W'(idx_full);
            assign dec_hit[gi]   = (dec_addr[gi] >= BASE_ADDR)
                                && (int'(dec_port[gi]) < NUM_PORTS)
                                && (int'(idx_full) < NUM_REGS)
                                && (int'(regid[1:0]) < REG_BYTES);
            assign dec_slot[gi]  = SLOT_W'(int'(dec_port[gi]) * NUM_REGS + int'(dec_idx[gi]));
        end
    endgenerate

    logic [REG_W-1:0]     cfg_arr  [NUM_SLOTS];
    logic [REG_W-1:0]     stat_arr [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] cfg_updated_reg;

    // ---------------- read path ----------------
    logic                 rd_valid_reg, rd_err_reg;
    logic [7:0]           rd_data_reg, rd_data_next;
    logic [REG_W-1:0]     snap_data_reg;
    logic [TAG_W-1:0]     snap_tag_reg;
    logic                 snap_valid_reg;
    logic [TAG_W-1:0]     rd_tag;
    logic [REG_W-1:0]     rd_live;
    logic [7:0]           rd_live_byte, rd_snap_byte;
    logic                 snap_match;

    assign rd_tag     = {dec_port[0], dec_idx[0]};
    assign rd_live    = RO_MASK[dec_idx[0]] ? stat_arr[dec_slot[0]] : cfg_arr[dec_slot[0]];
    assign snap_match = snap_valid_reg && (snap_tag_reg == rd_tag);

    always_comb begin
        rd_live_byte = '0;
        rd_snap_byte = '0;
        for (int b = 0; b < REG_BYTES; b++) begin
            if (dec_byte[0] == 2'(b)) begin
                rd_live_byte = rd_live[b*8 +: 8];
                rd_snap_byte = snap_data_reg[b*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_data_next = 8'h00;
        if (dec_hit[0]) begin
            rd_data_next = (dec_byte[0] != 2'd0 && snap_match) ? rd_snap_byte : rd_live_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg   <= 1'b0;
            rd_data_reg    <= 8'h00;
            rd_err_reg     <= 1'b0;
            snap_valid_reg <= 1'b0;
            snap_tag_reg   <= '0;
            snap_data_reg  <= '0;
        end else begin
            rd_valid_reg <= rd_en;
            rd_err_reg   <= rd_en && !dec_hit[0];
            rd_data_reg  <= rd_en ? rd_data_next : 8'h00;
            // A byte-0 read freezes the whole register for the following byte reads.
            if (rd_en && dec_hit[0] && dec_byte[0] == 2'd0) begin
                snap_data_reg  <= rd_live;
                snap_tag_reg   <= rd_tag;
                snap_valid_reg <= 1'b1;
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;
    assign rd_err   = rd_err_reg;

    // ---------------- write path ----------------
    logic [7:0]           stg_data_reg [STG_N];
    logic [STG_N-1:0]     stg_valid_reg, stg_valid_next;
    logic [TAG_W-1:0]     stg_tag_reg;
    logic [TAG_W-1:0]     wr_tag;
    logic                 wr_rw, wr_msb, wr_commit, wr_stage;
    logic [REG_W-1:0]     wr_new;
    logic [NUM_SLOTS-1:0] wr_onehot;

    assign wr_tag    = {dec_port[1], dec_idx[1]};
    assign wr_rw     = wr_en && dec_hit[1] && !RO_MASK[dec_idx[1]];
    assign wr_msb    = (dec_byte[1] == 2'(REG_BYTES - 1));
    assign wr_commit = wr_rw && wr_msb;
    assign wr_stage  = wr_rw && !wr_msb;
    assign wr_onehot = NUM_SLOTS'(1) << dec_slot[1];

    // Merge: MSB from the bus, staged bytes if they belong to this register, else current contents.
    always_comb begin
        wr_new = cfg_arr[dec_slot[1]];
        wr_new[REG_W-1 -: 8] = wr_data;
        for (int b = 0; b < REG_BYTES - 1; b++) begin
            if (stg_valid_reg[b] && stg_tag_reg == wr_tag) begin
                wr_new[b*8 +: 8] = stg_data_reg[b];
            end
        end
    end

    always_comb begin
        stg_valid_next = (stg_tag_reg == wr_tag) ? stg_valid_reg : '0;
        for (int b = 0; b < STG_N; b++) begin
            if (dec_byte[1] == 2'(b)) begin
                stg_valid_next[b] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_reg <= '0;
            stg_tag_reg   <= '0;
        end else if (wr_commit) begin
            stg_valid_reg <= '0;
        end else if (wr_stage) begin
            stg_valid_reg <= stg_valid_next;
            stg_tag_reg   <= wr_tag;
            for (int b = 0; b < STG_N; b++) begin
                if (dec_byte[1] == 2'(b)) begin
                    stg_data_reg[b] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_updated_reg <= '0;
        end else begin
            cfg_updated_reg <= wr_commit ? wr_onehot : '0;
        end
    end

    assign cfg_updated = cfg_updated_reg;

    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic [REG_W-1:0] val_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    val_reg <= '0;
                end else if (wr_commit && dec_slot[1] == SLOT_W'(gi)) begin
                    val_reg <= wr_new;
                end
            end

            assign cfg_arr[gi]                 = val_reg;
            assign cfg_out[gi*REG_W +: REG_W]  = val_reg;
            assign stat_arr[gi]                = stat_in[gi*REG_W +: REG_W];
        end
    endgenerate

endmodule
